// File: rtl/voice_allocator_pkg.sv
// Shared types for the voice allocator: FSM states, song-word field offsets and
// the free-voice priority encoder.
package voice_pkg;

    typedef enum logic [2:0] {
        ST_ASSIGN  = 3'd0,
        ST_LOAD    = 3'd1,
        ST_ADVANCE = 3'd2,
        ST_PAUSE   = 3'd3,
        ST_LISTEN  = 3'd4
    } state_t;

    localparam int MAX_VOICES = 8;
    localparam int STEREO_BIT = 2;
    localparam int DUR_LSB    = 3;

    typedef struct packed {
        logic       valid;
        logic [2:0] idx;
    } free_t;

    function automatic int note_lsb(input int dur_w);
        return DUR_LSB + dur_w;
    endfunction

    // Lowest-indexed clear bit; callers pad unused voices with ones.
    function automatic free_t first_free(input logic [MAX_VOICES-1:0] busy);
        free_t r;
        r = '0;
        for (int i = MAX_VOICES - 1; i >= 0; i--) begin
            if (!busy[i]) begin
                r.valid = 1'b1;
                r.idx   = 3'(i);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/voice_allocator_if.sv
// Song-reader / note-player side bus of the voice allocator.
// Strobes (load_new_note, beat, voice_done, voice_load, note_done) are single-cycle qualifiers; there is no backpressure.
interface voice_allocator_if #(
    parameter int NUM_VOICES = 3,
    parameter int NOTE_W     = 6,
    parameter int DUR_W      = 6,
    parameter int WORD_W     = NOTE_W + DUR_W + 4
);
    logic                         beat;
    logic                         play_enable;
    logic                         load_new_note;
    logic [WORD_W-1:0]            word_in;
    logic [NUM_VOICES-1:0]        voice_done;
    logic [NUM_VOICES-1:0]        voice_load;
    logic [NUM_VOICES*NOTE_W-1:0] voice_note;
    logic [NUM_VOICES*DUR_W-1:0]  voice_dur;
    logic [NUM_VOICES-1:0]        voice_stereo;
    logic                         note_done;
    logic                         advance_time;
    logic                         overflow;

    modport master (
        output beat, play_enable, load_new_note, word_in, voice_done,
        input  voice_load, voice_note, voice_dur, voice_stereo, note_done, advance_time, overflow
    );

    modport slave (
        input  beat, play_enable, load_new_note, word_in, voice_done,
        output voice_load, voice_note, voice_dur, voice_stereo, note_done, advance_time, overflow
    );
endinterface

// File: rtl/voice_allocator_voice_slot.sv
// Per-voice staging registers plus busy/dirty/done-pending bookkeeping.
module voice_slot
    import voice_pkg::*;
#(
    parameter int NOTE_W = 6,
    parameter int DUR_W  = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_stage,
    input  logic              i_rest,
    input  logic              i_load,
    input  logic              i_listen,
    input  logic              i_done,
    input  logic [NOTE_W-1:0] i_note,
    input  logic [DUR_W-1:0]  i_dur,
    input  logic              i_stereo,
    output logic              o_busy,
    output logic              o_dirty,
    output logic [NOTE_W-1:0] o_note,
    output logic [DUR_W-1:0]  o_dur,
    output logic              o_stereo
);
    logic r_pend;

    always_ff @(posedge clk) begin
        if (reset) begin
            o_note   <= '0;
            o_dur    <= '0;
            o_stereo <= 1'b0;
            o_busy   <= 1'b0;
            o_dirty  <= 1'b0;
            r_pend   <= 1'b0;
        end else begin
            if (i_stage) begin
                o_note   <= i_note;
                o_dur    <= i_dur;
                o_stereo <= i_stereo;
                o_busy   <= 1'b1;
                o_dirty  <= 1'b1;
            end else if (i_rest) begin
                o_note   <= '0;
                o_dur    <= i_dur;
                o_stereo <= 1'b0;
                o_dirty  <= 1'b1;
            end else if (i_load) begin
                o_dirty  <= 1'b0;
            end
            // A done landing in the listen cycle is kept for the next step.
            if (i_listen) begin
                o_busy <= o_busy & ~r_pend;
                r_pend <= i_done;
            end else begin
                r_pend <= r_pend | i_done;
            end
        end
    end
endmodule

// File: rtl/voice_allocator.sv
// Assigns song notes to the lowest free voice and sequences load/advance/listen steps.
// Optional macro VOICE_STEAL_EN: a note arriving with every voice busy overwrites a round-robin voice.
module voice_allocator
    import voice_pkg::*;
#(
    parameter int NUM_VOICES = 3,
    parameter int NOTE_W     = 6,
    parameter int DUR_W      = 6,
    parameter int WORD_W     = NOTE_W + DUR_W + 4
) (
    input  logic                  clk,
    input  logic                  reset,
    voice_allocator_if.slave      bus,
    output state_t                o_dbg_state,
    output logic [NUM_VOICES-1:0] o_dbg_busy
);
    localparam int NOTE_LSB = note_lsb(DUR_W);

    state_t                r_state, w_next;
    logic [DUR_W-1:0]      r_count, w_count_next;
    logic                  r_note_done, w_note_done;
    logic                  r_overflow, w_overflow_set;
    logic                  w_adv, w_load, w_listen;
    logic [NUM_VOICES-1:0] w_stage, w_rest, w_busy, w_dirty;
    logic [MAX_VOICES-1:0] w_busy_pad;
    free_t                 w_free;

    logic                  w_flag;
    logic [NOTE_W-1:0]     w_note;
    logic [DUR_W-1:0]      w_dur;
    logic                  w_stereo;

    logic [NOTE_W-1:0]     w_slot_note [NUM_VOICES];
    logic [DUR_W-1:0]      w_slot_dur  [NUM_VOICES];
    logic [NUM_VOICES-1:0] w_slot_st;

`ifdef VOICE_STEAL_EN
    logic [2:0] r_steal_ptr;
    logic       w_steal_adv;
`endif

    assign w_flag   = bus.word_in[WORD_W-1];
    assign w_note   = bus.word_in[NOTE_LSB +: NOTE_W];
    assign w_dur    = bus.word_in[DUR_LSB +: DUR_W];
    assign w_stereo = bus.word_in[STEREO_BIT];

    always_comb begin
        w_busy_pad                 = '1;
        w_busy_pad[NUM_VOICES-1:0] = w_busy;
        w_free                     = first_free(w_busy_pad);
    end

    always_comb begin
        w_next         = r_state;
        w_count_next   = r_count;
        w_note_done    = 1'b0;
        w_adv          = 1'b0;
        w_overflow_set = 1'b0;
        w_stage        = '0;
        w_rest         = '0;
`ifdef VOICE_STEAL_EN
        w_steal_adv    = 1'b0;
`endif
        case (r_state)
            ST_ASSIGN: begin
                if (bus.load_new_note) begin
                    if (w_flag) begin
                        // A zero duration still lasts one beat.
                        w_count_next = (w_dur == '0) ? '0 : w_dur - DUR_W'(1);
                        w_rest       = ~w_busy;
                        w_next       = ST_LOAD;
                    end else begin
                        w_note_done = 1'b1;
                        if (w_free.valid) begin
                            for (int i = 0; i < NUM_VOICES; i++)
                                if (w_free.idx == 3'(i)) w_stage[i] = 1'b1;
                        end else begin
                            w_overflow_set = 1'b1;
`ifdef VOICE_STEAL_EN
                            for (int i = 0; i < NUM_VOICES; i++)
                                if (r_steal_ptr == 3'(i)) w_stage[i] = 1'b1;
                            w_steal_adv = 1'b1;
`endif
                        end
                    end
                end
            end
            ST_LOAD: w_next = ST_ADVANCE;
            ST_ADVANCE: begin
                w_adv = 1'b1;
                if (bus.beat && r_count == '0) begin
                    w_note_done = 1'b1;
                    w_next      = ST_LISTEN;
                end else if (!bus.play_enable) begin
                    w_adv  = 1'b0;
                    w_next = ST_PAUSE;
                end else if (bus.beat) begin
                    w_count_next = r_count - DUR_W'(1);
                end
            end
            ST_PAUSE:  if (bus.play_enable) w_next = ST_ADVANCE;
            ST_LISTEN: w_next = ST_ASSIGN;
            default:   w_next = ST_ASSIGN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_ASSIGN;
            r_count     <= '0;
            r_note_done <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_count     <= w_count_next;
            r_note_done <= w_note_done;
            r_overflow  <= r_overflow | w_overflow_set;
        end
    end

`ifdef VOICE_STEAL_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            r_steal_ptr <= '0;
        end else if (w_steal_adv) begin
            r_steal_ptr <= (r_steal_ptr == 3'(NUM_VOICES - 1)) ? 3'd0 : r_steal_ptr + 3'd1;
        end
    end
`endif

    assign w_load   = (r_state == ST_LOAD);
    assign w_listen = (r_state == ST_LISTEN);

    for (genvar gi = 0; gi < NUM_VOICES; gi++) begin : g_slot
        voice_slot #(.NOTE_W(NOTE_W), .DUR_W(DUR_W)) u_slot (
            .clk      (clk),
            .reset    (reset),
            .i_stage  (w_stage[gi]),
            .i_rest   (w_rest[gi]),
            .i_load   (w_load),
            .i_listen (w_listen),
            .i_done   (bus.voice_done[gi]),
            .i_note   (w_note),
            .i_dur    (w_dur),
            .i_stereo (w_stereo),
            .o_busy   (w_busy[gi]),
            .o_dirty  (w_dirty[gi]),
            .o_note   (w_slot_note[gi]),
            .o_dur    (w_slot_dur[gi]),
            .o_stereo (w_slot_st[gi])
        );
    end

    always_comb begin
        bus.voice_note = '0;
        bus.voice_dur  = '0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            bus.voice_note[i*NOTE_W +: NOTE_W] = w_slot_note[i];
            bus.voice_dur[i*DUR_W +: DUR_W]    = w_slot_dur[i];
        end
    end

    assign bus.voice_stereo = w_slot_st;
    assign bus.voice_load   = w_load ? w_dirty : '0;
    assign bus.note_done    = r_note_done;
    assign bus.advance_time = w_adv;
    assign bus.overflow     = r_overflow;
    assign o_dbg_state      = r_state;
    assign o_dbg_busy       = w_busy;
endmodule

// File: tb/tb_voice_allocator.sv
// Self-checking bench for voice_allocator against a voice-table reference model.
module tb_voice_allocator;
    import voice_pkg::*;

    localparam int NV = 3;
    localparam int NW = 6;
    localparam int DW = 6;
    localparam int WW = NW + DW + 4;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    voice_allocator_if #(.NUM_VOICES(NV), .NOTE_W(NW), .DUR_W(DW), .WORD_W(WW)) bus();
    state_t        dbg_state;
    logic [NV-1:0] dbg_busy;

    voice_allocator #(.NUM_VOICES(NV), .NOTE_W(NW), .DUR_W(DW), .WORD_W(WW)) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .o_dbg_state (dbg_state),
        .o_dbg_busy  (dbg_busy)
    );

    int checks   = 0;
    int failures = 0;

    // ---------------- reference model ----------------
    logic [NV-1:0] m_busy, m_dirty, m_pend, m_st;
    logic [NW-1:0] m_note [NV];
    logic [DW-1:0] m_dur  [NV];
    logic          m_ovf;
    int            m_steal;
    logic [NV-1:0] exp_q[$];

    task automatic m_reset();
        m_busy = '0; m_dirty = '0; m_pend = '0; m_st = '0; m_ovf = 1'b0; m_steal = 0;
        for (int i = 0; i < NV; i++) begin m_note[i] = '0; m_dur[i] = '0; end
        exp_q.delete();
    endtask

    task automatic m_note_in(input logic [NW-1:0] n, input logic [DW-1:0] d, input logic s);
        int v;
        v = -1;
        for (int i = 0; i < NV; i++) if (!m_busy[i]) begin v = i; break; end
        if (v < 0) begin
            m_ovf = 1'b1;
`ifdef VOICE_STEAL_EN
            v = m_steal;
            m_steal = (m_steal + 1) % NV;
`endif
        end
        if (v >= 0) begin
            m_note[v] = n; m_dur[v] = d; m_st[v] = s;
            m_busy[v] = 1'b1; m_dirty[v] = 1'b1;
        end
    endtask

    task automatic m_advance(input logic [DW-1:0] d);
        for (int i = 0; i < NV; i++) if (!m_busy[i]) begin
            m_note[i] = '0; m_dur[i] = d; m_st[i] = 1'b0; m_dirty[i] = 1'b1;
        end
        exp_q.push_back(m_dirty);
        m_dirty = '0;
    endtask

    task automatic m_listen();
        m_busy = m_busy & ~m_pend;
        m_pend = '0;
    endtask

    function automatic logic [NV*NW-1:0] exp_notes();
        logic [NV*NW-1:0] r;
        for (int i = 0; i < NV; i++) r[i*NW +: NW] = m_note[i];
        return r;
    endfunction

    function automatic logic [NV*DW-1:0] exp_durs();
        logic [NV*DW-1:0] r;
        for (int i = 0; i < NV; i++) r[i*DW +: DW] = m_dur[i];
        return r;
    endfunction

    function automatic logic [WW-1:0] mk_note(input logic [NW-1:0] n, input logic [DW-1:0] d, input logic s);
        logic [1:0] rsv;
        rsv = 2'($urandom);
        return {1'b0, n, d, s, rsv};
    endfunction

    function automatic logic [WW-1:0] mk_adv(input logic [DW-1:0] d);
        logic [NW-1:0] z;
        z = '0;
        return {1'b1, z, d, 1'b0, 2'b11};
    endfunction

    // ---------------- drivers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_word(input logic [WW-1:0] w);
        bus.load_new_note = 1'b1;
        bus.word_in       = w;
        tick();
        bus.load_new_note = 1'b0;
    endtask

    task automatic pulse_beat();
        bus.beat = 1'b1;
        tick();
        bus.beat = 1'b0;
    endtask

    task automatic pulse_done(input logic [NV-1:0] mask);
        bus.voice_done = mask;
        tick();
        bus.voice_done = '0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.load_new_note = 1'b0; bus.beat = 1'b0; bus.voice_done = '0;
        bus.play_enable = 1'b1; bus.word_in = '0;
        tick(); tick();
        reset = 1'b0;
        m_reset();
    endtask

    task automatic do_advance(input logic [DW-1:0] d, output logic [NV-1:0] ld, output state_t st);
        drive_word(mk_adv(d));
        ld = bus.voice_load;
        st = dbg_state;
        tick();
    endtask

    // Beats until note_done shows up (bounded); returns the beat index or 0.
    task automatic do_beats(input int max_beats, output int k);
        k = 0;
        for (int b = 1; b <= max_beats; b++) begin
            pulse_beat();
            if (bus.note_done) begin k = b; break; end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        do_reset();
        checks++; if (dbg_state !== ST_ASSIGN) begin failures++; $display("FAIL reset_state: got %0d want %0d", dbg_state, ST_ASSIGN); end
        checks++; if ({bus.voice_load, bus.note_done, bus.advance_time, bus.overflow} !== '0) begin
            failures++; $display("FAIL reset_ctrl: load=%b nd=%b adv=%b ovf=%b want 0", bus.voice_load, bus.note_done, bus.advance_time, bus.overflow); end
        checks++; if ({bus.voice_note, bus.voice_dur, bus.voice_stereo} !== {exp_notes(), exp_durs(), m_st}) begin
            failures++; $display("FAIL reset_staged: note=%h dur=%h st=%b want 0", bus.voice_note, bus.voice_dur, bus.voice_stereo); end
        checks++; if (dbg_busy !== '0) begin failures++; $display("FAIL reset_busy: got %b want 0", dbg_busy); end
    endtask

    task automatic test_step_basic();
        logic [NV-1:0] ld, e; state_t st; int k;
        drive_word(mk_note(6'd5, 6'd12, 1'b0)); m_note_in(6'd5, 6'd12, 1'b0);
        checks++; if (bus.note_done !== 1'b1) begin failures++; $display("FAIL basic_note_done: got %b want 1", bus.note_done); end
        checks++; if (bus.voice_note !== exp_notes()) begin failures++; $display("FAIL basic_note_a: got %h want %h", bus.voice_note, exp_notes()); end
        drive_word(mk_note(6'd9, 6'd6, 1'b1)); m_note_in(6'd9, 6'd6, 1'b1);
        checks++; if (bus.voice_stereo !== m_st) begin failures++; $display("FAIL basic_stereo: got %b want %b", bus.voice_stereo, m_st); end
        checks++; if (dbg_busy !== m_busy) begin failures++; $display("FAIL basic_busy: got %b want %b", dbg_busy, m_busy); end
        do_advance(6'd4, ld, st); m_advance(6'd4); e = exp_q.pop_front();
        checks++; if (ld !== e) begin failures++; $display("FAIL basic_load: got %b want %b", ld, e); end
        checks++; if (st !== ST_LOAD) begin failures++; $display("FAIL basic_load_state: got %0d want %0d", st, ST_LOAD); end
        checks++; if ({bus.voice_note, bus.voice_dur} !== {exp_notes(), exp_durs()}) begin
            failures++; $display("FAIL basic_staged: note=%h dur=%h want %h %h", bus.voice_note, bus.voice_dur, exp_notes(), exp_durs()); end
        checks++; if (bus.advance_time !== 1'b1) begin failures++; $display("FAIL basic_adv: got %b want 1", bus.advance_time); end
        do_beats(20, k);
        checks++; if (k !== 4) begin failures++; $display("FAIL basic_beats: got %0d want 4", k); end
        checks++; if (dbg_state !== ST_LISTEN) begin failures++; $display("FAIL basic_listen: got %0d want %0d", dbg_state, ST_LISTEN); end
        tick(); m_listen();
        checks++; if (dbg_busy !== m_busy) begin failures++; $display("FAIL basic_busy_end: got %b want %b", dbg_busy, m_busy); end
    endtask

    task automatic test_done_reuse();
        logic [NV-1:0] ld, e; state_t st; int k;
        do_advance(6'd2, ld, st); m_advance(6'd2); e = exp_q.pop_front();
        checks++; if (ld !== e) begin failures++; $display("FAIL reuse_load1: got %b want %b", ld, e); end
        pulse_done(3'b010); m_pend |= 3'b010;
        do_beats(20, k);
        checks++; if (k !== 2) begin failures++; $display("FAIL reuse_beats: got %0d want 2", k); end
        tick(); m_listen();
        checks++; if (dbg_busy !== m_busy) begin failures++; $display("FAIL reuse_busy: got %b want %b", dbg_busy, m_busy); end
        drive_word(mk_note(6'd7, 6'd3, 1'b1)); m_note_in(6'd7, 6'd3, 1'b1);
        checks++; if (bus.voice_note !== exp_notes()) begin failures++; $display("FAIL reuse_note: got %h want %h", bus.voice_note, exp_notes()); end
        do_advance(6'd1, ld, st); m_advance(6'd1); e = exp_q.pop_front();
        checks++; if (ld !== e) begin failures++; $display("FAIL reuse_load2: got %b want %b", ld, e); end
        do_beats(20, k); tick(); m_listen();
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 0; i < NV; i++) begin
            drive_word(mk_note(NW'(10 + i), DW'(i + 1), 1'b1)); m_note_in(NW'(10 + i), DW'(i + 1), 1'b1);
        end
        checks++; if (bus.overflow !== 1'b0) begin failures++; $display("FAIL ovf_early: got %b want 0", bus.overflow); end
        drive_word(mk_note(6'd33, 6'd9, 1'b0)); m_note_in(6'd33, 6'd9, 1'b0);
        checks++; if (bus.note_done !== 1'b1) begin failures++; $display("FAIL ovf_note_done: got %b want 1", bus.note_done); end
        checks++; if ({bus.voice_note, bus.voice_dur, bus.voice_stereo} !== {exp_notes(), exp_durs(), m_st}) begin
            failures++; $display("FAIL ovf_staged: note=%h dur=%h st=%b want %h %h %b", bus.voice_note, bus.voice_dur, bus.voice_stereo, exp_notes(), exp_durs(), m_st); end
        tick();
        checks++; if (bus.overflow !== m_ovf) begin failures++; $display("FAIL ovf_sticky: got %b want %b", bus.overflow, m_ovf); end
    endtask

    task automatic test_pause();
        logic [NV-1:0] ld, e; state_t st; int k;
        do_reset();
        do_advance(6'd3, ld, st); m_advance(6'd3); e = exp_q.pop_front();
        checks++; if (ld !== e) begin failures++; $display("FAIL pause_load: got %b want %b", ld, e); end
        pulse_beat();
        bus.play_enable = 1'b0;
        #1;
        checks++; if (bus.advance_time !== 1'b0) begin failures++; $display("FAIL pause_adv_drop: got %b want 0", bus.advance_time); end
        tick();
        for (int i = 0; i < 5; i++) begin
            pulse_beat();
            checks++; if (bus.advance_time !== 1'b0 || dbg_state !== ST_PAUSE) begin
                failures++; $display("FAIL pause_hold: adv=%b state=%0d want 0 %0d", bus.advance_time, dbg_state, ST_PAUSE); end
        end
        bus.play_enable = 1'b1;
        tick();
        do_beats(20, k);
        checks++; if (k !== 2) begin failures++; $display("FAIL pause_beats: got %0d want 2", k); end
        tick(); m_listen();
    endtask

    task automatic test_listen_done();
        logic [NV-1:0] ld, e; state_t st; int k;
        do_reset();
        drive_word(mk_note(6'd1, 6'd1, 1'b0)); m_note_in(6'd1, 6'd1, 1'b0);
        do_advance(6'd1, ld, st); m_advance(6'd1); e = exp_q.pop_front();
        do_beats(20, k);
        checks++; if (dbg_state !== ST_LISTEN) begin failures++; $display("FAIL ld_listen: got %0d want %0d", dbg_state, ST_LISTEN); end
        pulse_done(3'b001); m_listen(); m_pend |= 3'b001;
        checks++; if (dbg_busy !== m_busy) begin failures++; $display("FAIL ld_busy_kept: got %b want %b", dbg_busy, m_busy); end
        do_advance(6'd1, ld, st); m_advance(6'd1); e = exp_q.pop_front();
        checks++; if (ld !== e) begin failures++; $display("FAIL ld_load: got %b want %b", ld, e); end
        do_beats(20, k); tick(); m_listen();
        checks++; if (dbg_busy !== m_busy) begin failures++; $display("FAIL ld_busy_freed: got %b want %b", dbg_busy, m_busy); end
    endtask

    task automatic test_reset_mid();
        logic [NV-1:0] ld; state_t st;
        do_reset();
        for (int i = 0; i < NV; i++) begin
            drive_word(mk_note(NW'(20 + i), DW'(4), 1'b1)); m_note_in(NW'(20 + i), DW'(4), 1'b1);
        end
        do_advance(6'd5, ld, st); m_advance(6'd5);
        pulse_beat();
        checks++; if (dbg_state !== ST_ADVANCE || dbg_busy !== m_busy) begin
            failures++; $display("FAIL mid_pre: state=%0d busy=%b want %0d %b", dbg_state, dbg_busy, ST_ADVANCE, m_busy); end
        reset = 1'b1;
        tick();
        m_reset();
        checks++; if (dbg_state !== ST_ASSIGN) begin failures++; $display("FAIL mid_state: got %0d want %0d", dbg_state, ST_ASSIGN); end
        checks++; if ({bus.voice_load, bus.voice_note, bus.voice_dur, bus.voice_stereo, bus.note_done, bus.advance_time, bus.overflow, dbg_busy} !== '0) begin
            failures++; $display("FAIL mid_outputs: load=%b note=%h dur=%h adv=%b ovf=%b busy=%b want 0", bus.voice_load, bus.voice_note, bus.voice_dur, bus.advance_time, bus.overflow, dbg_busy); end
        bus.load_new_note = 1'b1; bus.word_in = mk_note(6'd44, 6'd2, 1'b1);
        tick();
        bus.load_new_note = 1'b0; reset = 1'b0;
        checks++; if ({bus.note_done, bus.voice_note, dbg_busy} !== '0) begin
            failures++; $display("FAIL strobe_vs_reset: nd=%b note=%h busy=%b want 0", bus.note_done, bus.voice_note, dbg_busy); end
    endtask

    task automatic test_random();
        logic [NV-1:0] ld, e, mask; state_t st;
        logic [NW-1:0] n; logic [DW-1:0] d; logic s; int need;
        do_reset();
        for (int step = 0; step < 25; step++) begin
            for (int j = 0; j < int'($urandom_range(0, 4)); j++) begin
                n = NW'($urandom_range(0, 63)); d = DW'($urandom_range(0, 63)); s = 1'($urandom);
                drive_word(mk_note(n, d, s)); m_note_in(n, d, s);
                checks++; if ({bus.note_done, bus.overflow} !== {1'b1, m_ovf}) begin
                    failures++; $display("FAIL rnd_note_flags: nd=%b ovf=%b want 1 %b", bus.note_done, bus.overflow, m_ovf); end
                checks++; if ({bus.voice_note, bus.voice_dur, bus.voice_stereo} !== {exp_notes(), exp_durs(), m_st}) begin
                    failures++; $display("FAIL rnd_staged: note=%h dur=%h st=%b want %h %h %b", bus.voice_note, bus.voice_dur, bus.voice_stereo, exp_notes(), exp_durs(), m_st); end
                if ($urandom_range(0, 2) == 0) begin
                    mask = NV'($urandom_range(0, 7)); pulse_done(mask); m_pend |= mask;
                end
            end
            d = DW'($urandom_range(0, 7));
            need = (d == 0) ? 1 : int'(d);
            do_advance(d, ld, st); m_advance(d); e = exp_q.pop_front();
            checks++; if (ld !== e) begin failures++; $display("FAIL rnd_load: got %b want %b", ld, e); end
            for (int b = 1; b <= need; b++) begin
                if ($urandom_range(0, 3) == 0) begin
                    mask = NV'($urandom_range(0, 7)); pulse_done(mask); m_pend |= mask;
                end
                if ($urandom_range(0, 4) == 0) begin
                    bus.play_enable = 1'b0; tick();
                    repeat ($urandom_range(1, 3)) pulse_beat();
                    bus.play_enable = 1'b1; tick();
                end
                pulse_beat();
                checks++; if (bus.note_done !== 1'(b == need)) begin
                    failures++; $display("FAIL rnd_step_end: beat %0d of %0d note_done=%b", b, need, bus.note_done); end
            end
            mask = NV'($urandom_range(0, 7));
            pulse_done(mask); m_listen(); m_pend |= mask;
            checks++; if (dbg_state !== ST_ASSIGN || dbg_busy !== m_busy) begin
                failures++; $display("FAIL rnd_busy: state=%0d busy=%b want %0d %b", dbg_state, dbg_busy, ST_ASSIGN, m_busy); end
        end
    endtask

    initial begin
        #2_000_000;
        failures++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_step_basic();
        test_done_reuse();
        test_overflow();
        test_pause();
        test_listen_done();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
